// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the single-lane SPI-flash word reader.
package spi_flash_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP, GAP} state_e;

  localparam logic [7:0]  SPI_CMD_READ   = 8'h03;
  localparam int unsigned CMD_ADDR_BITS  = 32;
  localparam int unsigned MAX_WORD_BYTES = 4;

  // Serial frame length: command + address + data bits.
  function automatic int unsigned frame_bits(input int unsigned word_bytes);
    return CMD_ADDR_BITS + 8 * word_bytes;
  endfunction

endpackage

// File: rtl/spi_sck_phase_gen.sv
// SPI mode-0 clock generator: CLK_DIV cycles low, CLK_DIV cycles high, with
// strobes marking the cycle before each sck register transition.
module spi_sck_phase_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          last;

  assign last = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    rise  = 1'b0;
    fall  = 1'b0;
    if (!enable) begin
      // Disabled: park low so the next transaction starts with a full low phase.
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      sck_d = ~sck_q;
      rise  = ~sck_q;
      fall  = sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/spi_flash_word_reader.sv
// Single-lane SPI-flash READ (0x03) engine: one request in, one little-endian
// word out, with a minimum chip-select gap between transactions.
module spi_flash_word_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned NBITS = frame_bits(WORD_BYTES);
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned GW    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned YW    = $clog2(MAX_WORD_BYTES);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [YW-1:0]    byte_q, byte_d;
  logic [6:0]       rx_q, rx_d;
  logic [31:0]      data_q, data_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             cs_q, cs_d;
  logic             valid_q, valid_d;

  logic shift_en, sck, sck_rise, sck_fall, gap_done, data_phase;

  assign shift_en   = (state_q == SHIFT);
  // gap_q counts completed cs-high cycles; the current one makes gap_q + 1.
  assign gap_done   = (gap_q >= GW'(CS_GAP - 1));
  assign data_phase = (bit_q >= BW'(CMD_ADDR_BITS));

  spi_sck_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clock  (clock),
    .reset  (reset),
    .enable (shift_en),
    .sck    (sck),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rx_d    = rx_q;
    data_d  = data_q;
    gap_d   = gap_q;
    cs_d    = cs_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SHIFT;
          sh_d    = {SPI_CMD_READ, req_addr, {(NBITS - CMD_ADDR_BITS){1'b0}}};
          bit_d   = '0;
          byte_d  = '0;
          cs_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (sck_rise && data_phase) begin
          rx_d = {rx_q[5:0], spi_miso};
          if (bit_q[2:0] == 3'd7) begin
            data_d[8*byte_q +: 8] = {rx_q, spi_miso};
            byte_d                = byte_q + YW'(1);
          end
        end
        // MOSI advances only as sck falls, so it is stable across the high phase.
        if (sck_fall) begin
          sh_d  = {sh_q[NBITS-2:0], 1'b0};
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(NBITS - 1)) begin
            state_d = RESP;
            cs_d    = 1'b1;
            valid_d = 1'b1;
            gap_d   = '0;
          end
        end
      end
      RESP: begin
        if (!gap_done) gap_d = gap_q + GW'(1);
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = gap_done ? IDLE : GAP;
        end
      end
      GAP: begin
        if (!gap_done) gap_d = gap_q + GW'(1);
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == SHIFT) || (state_q == RESP);
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign spi_cs     = cs_q;
  assign spi_sck    = sck;
  assign spi_mosi   = sh_q[NBITS-1];

endmodule
